// File: rtl/keyboard_keycode_rx.sv
// rtl/keyboard_keycode_rx.sv - PS/2 keyboard frame receiver with scancode-to-HID keycode decoder
module keyboard_keycode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic [7:0] scan_byte,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt, clk_filt_prev;
  logic [FW-1:0] filt_cnt;
  logic          strobe;

  state_t        state, state_next;
  logic [7:0]    shift_reg, shift_next;
  logic [2:0]    bit_cnt, bit_cnt_next;
  logic          par_bit, par_next;
  logic [TW-1:0] tmo_cnt, tmo_next;
  logic          frame_good, frame_bad;

  logic          ext_flag, brk_flag;
  logic [7:0]    mapped;

  // Synchronize both PS/2 lines and debounce the clock: a level change is
  // accepted only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      clk_s1        <= 1'b1;
      clk_s2        <= 1'b1;
      dat_s1        <= 1'b1;
      dat_s2        <= 1'b1;
      clk_filt      <= 1'b1;
      clk_filt_prev <= 1'b1;
      filt_cnt      <= '0;
    end else begin
      clk_s1        <= ps2_clk;
      clk_s2        <= clk_s1;
      dat_s1        <= ps2_data;
      dat_s2        <= dat_s1;
      clk_filt_prev <= clk_filt;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_MAX) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign strobe = clk_filt_prev & ~clk_filt;

  // Frame FSM: one transition per falling-edge strobe, plus inter-strobe timeout.
  always_comb begin
    state_next   = state;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt;
    par_next     = par_bit;
    tmo_next     = '0;
    frame_good   = 1'b0;
    frame_bad    = 1'b0;
    if (state != IDLE && !strobe) begin
      if (tmo_cnt == TMO_MAX) begin
        frame_bad  = 1'b1;
        state_next = IDLE;
      end else begin
        tmo_next = tmo_cnt + 1'b1;
      end
    end
    if (strobe) begin
      case (state)
        IDLE: begin
          if (!dat_s2) begin
            state_next   = DATA;
            bit_cnt_next = 3'd0;
          end
        end
        DATA: begin
          shift_next   = {dat_s2, shift_reg[7:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = PARITY;
        end
        PARITY: begin
          par_next   = dat_s2;
          state_next = STOP;
        end
        STOP: begin
          state_next = IDLE;
          if ((^shift_reg ^ par_bit) && dat_s2) frame_good = 1'b1;
          else                                  frame_bad  = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Frame state register and registered byte/pulse outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      par_bit    <= 1'b0;
      tmo_cnt    <= '0;
      scan_byte  <= '0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_next;
      shift_reg  <= shift_next;
      bit_cnt    <= bit_cnt_next;
      par_bit    <= par_next;
      tmo_cnt    <= tmo_next;
      scan_valid <= frame_good;
      frame_err  <= frame_bad;
      if (frame_good) scan_byte <= shift_reg;
    end
  end

  // Scancode lookup; zero means the code is not one we report.
  always_comb begin
    mapped = 8'h00;
    case ({ext_flag, scan_byte})
      9'h01D:  mapped = 8'h1A;
      9'h01B:  mapped = 8'h16;
      9'h029:  mapped = 8'h2C;
      9'h05A:  mapped = 8'h28;
      9'h00D:  mapped = 8'h2B;
      9'h066:  mapped = 8'h2A;
      9'h175:  mapped = 8'h52;
      9'h172:  mapped = 8'h51;
      default: mapped = 8'h00;
    endcase
  end

  // Prefix tracking and held-key update, one cycle after each accepted byte.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      keycode  <= '0;
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (frame_bad) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (scan_valid) begin
      if (scan_byte == 8'hE0) begin
        ext_flag <= 1'b1;
      end else if (scan_byte == 8'hF0) begin
        brk_flag <= 1'b1;
      end else begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
        if (mapped != 8'h00) begin
          if (!brk_flag)             keycode <= mapped;
          else if (keycode == mapped) keycode <= 8'h00;
        end
      end
    end
  end

endmodule

// File: tb/tb_keyboard_keycode_rx.sv
// tb/tb_keyboard_keycode_rx.sv - randomized bench for keyboard_keycode_rx with behavioural reference
module tb_keyboard_keycode_rx;
  localparam int FL  = 8;
  localparam int TMO = 300;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keycode, scan_byte;
  logic       scan_valid, frame_err;

  keyboard_keycode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .Clk(Clk), .Reset(Reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keycode(keycode), .scan_byte(scan_byte), .scan_valid(scan_valid), .frame_err(frame_err)
  );

  always #5 Clk = ~Clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int valid_seen = 0;
  int err_seen = 0;

  // reference model state
  bit         m_live = 0;
  bit         ch[2];
  bit         dh[2];
  bit         win[$];
  bit         m_filt, m_strobe, m_in_frame;
  bit         m_bits[$];
  int         m_tmo;
  bit         m_ext, m_brk, m_valid, m_err;
  logic [7:0] m_key, m_byte;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [7:0] map_code(input bit ext, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    if (!ext) begin
      case (b)
        8'h1D: r = 8'h1A;
        8'h1B: r = 8'h16;
        8'h29: r = 8'h2C;
        8'h5A: r = 8'h28;
        8'h0D: r = 8'h2B;
        8'h66: r = 8'h2A;
        default: r = 8'h00;
      endcase
    end else begin
      case (b)
        8'h75: r = 8'h52;
        8'h72: r = 8'h51;
        default: r = 8'h00;
      endcase
    end
    return r;
  endfunction

  // Reference model: expected output values after each rising edge.
  always @(posedge Clk) begin : model
    bit         s, d, nv, ne, all_new;
    int         ones;
    logic [7:0] mp;
    if (Reset) begin
      m_live = 1;
      ch[0] = 1; ch[1] = 1; dh[0] = 1; dh[1] = 1;
      win.delete();
      m_filt = 1; m_strobe = 0; m_in_frame = 0; m_tmo = 0;
      m_ext = 0; m_brk = 0; m_key = 8'h00; m_byte = 8'h00; m_valid = 0; m_err = 0;
    end else begin
      if (m_valid) begin
        if (m_byte == 8'hE0) m_ext = 1;
        else if (m_byte == 8'hF0) m_brk = 1;
        else begin
          mp = map_code(m_ext, m_byte);
          if (mp != 8'h00) begin
            if (!m_brk) m_key = mp;
            else if (m_key == mp) m_key = 8'h00;
          end
          m_ext = 0;
          m_brk = 0;
        end
      end
      nv = 0; ne = 0; d = dh[1];
      if (m_strobe) begin
        if (!m_in_frame) begin
          if (!d) begin
            m_in_frame = 1;
            m_bits.delete();
            m_tmo = 0;
          end
        end else begin
          m_bits.push_back(d);
          m_tmo = 0;
          if (m_bits.size() == 10) begin
            ones = 0;
            for (int i = 0; i < 9; i++) ones += int'(m_bits[i]);
            m_in_frame = 0;
            if ((ones % 2 == 1) && m_bits[9]) begin
              nv = 1;
              for (int i = 0; i < 8; i++) m_byte[i] = m_bits[i];
            end else begin
              ne = 1;
            end
          end
        end
      end else if (m_in_frame) begin
        m_tmo++;
        if (m_tmo == TMO) begin
          ne = 1;
          m_in_frame = 0;
        end
      end
      if (ne) begin
        m_ext = 0;
        m_brk = 0;
      end
      m_valid = nv;
      m_err = ne;
      s = ch[1]; ch[1] = ch[0]; ch[0] = ps2_clk;
      dh[1] = dh[0]; dh[0] = ps2_data;
      win.push_back(s);
      if (win.size() > FL) void'(win.pop_front());
      m_strobe = 0;
      if (win.size() == FL) begin
        all_new = 1;
        foreach (win[i]) if (win[i] == m_filt) all_new = 0;
        if (all_new) begin
          m_filt = s;
          m_strobe = !s;
        end
      end
    end
  end

  // Compare DUT outputs to the model every cycle, away from the rising edge.
  always @(negedge Clk) begin
    if (m_live) begin
      check("keycode", keycode, m_key);
      check("scan_byte", scan_byte, m_byte);
      check("scan_valid", scan_valid, m_valid);
      check("frame_err", frame_err, m_err);
      valid_seen += int'(scan_valid);
      err_seen += int'(frame_err);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      idle($urandom_range(14, 22));
      ps2_clk = 1'b0;
      idle($urandom_range(14, 22));
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    idle(40);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, e0;
    logic [7:0] codes [12];
    logic [7:0] b;
    int nb;
    codes = '{8'h1D, 8'h1B, 8'h29, 8'h5A, 8'h0D, 8'h66, 8'h75, 8'h72, 8'hE0, 8'hF0, 8'hF0, 8'hE0};

    Reset = 1'b1;
    idle(3);
    check("rst_keycode", keycode, 8'h00);
    check("rst_scan_byte", scan_byte, 8'h00);
    check("rst_scan_valid", scan_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    Reset = 1'b0;
    idle(20);

    v0 = valid_seen; e0 = err_seen;
    send_good(8'h1D);
    check("1D_scan_byte", scan_byte, 8'h1D);
    check("1D_valid_pulses", valid_seen - v0, 1);
    check("1D_err_pulses", err_seen - e0, 0);
    check("1D_keycode", keycode, 8'h1A);
    send_good(8'hF0); send_good(8'h1D);
    check("brk_1D_keycode", keycode, 8'h00);

    send_good(8'hE0); send_good(8'h75);
    check("up_keycode", keycode, 8'h52);
    send_good(8'hE0); send_good(8'hF0); send_good(8'h75);
    check("brk_up_keycode", keycode, 8'h00);
    send_good(8'h1D);
    send_good(8'hE0); send_good(8'h1D);
    check("ext_1D_unmapped", keycode, 8'h1A);

    send_good(8'h29);
    check("space_over_W", keycode, 8'h2C);
    send_good(8'h29);
    check("typematic_space", keycode, 8'h2C);
    send_good(8'hF0); send_good(8'h1D);
    check("brk_W_keeps_space", keycode, 8'h2C);
    send_good(8'hF0); send_good(8'h29);
    check("brk_space", keycode, 8'h00);

    send_good(8'h1D);
    v0 = valid_seen; e0 = err_seen;
    send_frame(8'h1B, 1'b1, 1'b0, 11);
    check("badpar_err_pulses", err_seen - e0, 1);
    check("badpar_valid_pulses", valid_seen - v0, 0);
    check("badpar_scan_byte", scan_byte, 8'h1D);
    check("badpar_keycode", keycode, 8'h1A);
    v0 = valid_seen; e0 = err_seen;
    send_frame(8'h1B, 1'b0, 1'b1, 11);
    check("badstop_err_pulses", err_seen - e0, 1);
    check("badstop_valid_pulses", valid_seen - v0, 0);
    check("badstop_scan_byte", scan_byte, 8'h1D);
    check("badstop_keycode", keycode, 8'h1A);

    v0 = valid_seen; e0 = err_seen;
    send_frame(8'hA5, 1'b0, 1'b0, 5);
    idle(TMO + 50);
    check("timeout_err_pulses", err_seen - e0, 1);
    check("timeout_valid_pulses", valid_seen - v0, 0);
    send_good(8'h5A);
    check("enter_after_timeout", keycode, 8'h28);

    v0 = valid_seen; e0 = err_seen;
    ps2_clk = 1'b0;
    idle(3);
    ps2_clk = 1'b1;
    idle(30);
    check("glitch_valid_pulses", valid_seen - v0, 0);
    check("glitch_err_pulses", err_seen - e0, 0);
    check("glitch_keycode", keycode, 8'h28);
    send_good(8'h0D);
    check("tab_after_glitch", keycode, 8'h2B);

    v0 = valid_seen; e0 = err_seen;
    send_frame(8'h29, 1'b0, 1'b0, 5);
    Reset = 1'b1;
    idle(1);
    Reset = 1'b0;
    idle(TMO + 50);
    check("midrst_keycode", keycode, 8'h00);
    check("midrst_scan_byte", scan_byte, 8'h00);
    check("midrst_valid_pulses", valid_seen - v0, 0);
    check("midrst_err_pulses", err_seen - e0, 0);
    send_good(8'h66);
    check("bksp_after_reset", keycode, 8'h2A);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 5) == 0) b = 8'($urandom_range(0, 255));
      else b = codes[$urandom_range(0, 11)];
      nb = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 10) : 11;
      send_frame(b, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, nb);
      if (nb < 11) idle(TMO + 10);
      if ($urandom_range(0, 9) == 0) begin
        ps2_clk = 1'b0;
        idle($urandom_range(1, FL - 2));
        ps2_clk = 1'b1;
        idle(20);
      end
    end
    idle(20);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/keyboard_keycode_rx.md
KEYBOARD_KEYCODE_RX -- requirements
Module: keyboard_keycode_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8, meaning the number of consecutive equal synchronized samples needed to accept a ps2_clk level change.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning the maximum number of Clk cycles between filtered ps2_clk falling edges inside a frame.
REQ-003 SHALL have port Clk, input, 1 bit: the single system clock; all logic is rising-edge on Clk.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port ps2_clk, input, 1 bit: raw PS/2 clock, asynchronous, idle high.
REQ-006 SHALL have port ps2_data, input, 1 bit: raw PS/2 data, asynchronous, idle high.
REQ-007 SHALL have port keycode, output, 8 bits: HID-style code of the held key, 8'h00 when no mapped key is held.
REQ-008 SHALL have port scan_byte, output, 8 bits: last correctly received scancode byte.
REQ-009 SHALL have port scan_valid, output, 1 bit: one-cycle pulse when scan_byte updates.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a parity, stop-bit or timeout error.

Function
REQ-011 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers; the filtered ps2_clk changes only after FILTER_LEN equal consecutive synchronized samples.
REQ-012 SHALL treat a filtered ps2_clk 1->0 transition as a bit strobe and sample the synchronized ps2_data in that same cycle.
REQ-013 SHALL implement the frame FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, with one state transition per bit strobe.
REQ-014 In IDLE, a strobe with data 0 (start bit) SHALL go to DATA; a strobe with data 1 SHALL be ignored, leaving the FSM in IDLE with no error.
REQ-015 DATA SHALL shift in 8 bits LSB first using a 3-bit counter, then go to PARITY.
REQ-016 PARITY SHALL require odd parity over the 8 data bits plus the parity bit.
REQ-017 STOP SHALL require data 1.
REQ-018 When parity and stop bit are both good, the block SHALL load scan_byte and pulse scan_valid in the cycle after the stop strobe.
REQ-019 On a parity or stop error, the block SHALL pulse frame_err, leave scan_byte unchanged, clear the prefix flags and return to IDLE.
REQ-020 A timeout counter SHALL reset on every strobe and run while the FSM is not in IDLE; when it reaches TIMEOUT_CYCLES it SHALL pulse frame_err, return to IDLE and clear the prefix flags.
REQ-021 Decoder: byte 8'hE0 SHALL set the ext flag; byte 8'hF0 SHALL set the brk flag; any other byte SHALL be decoded with the current flags, after which both flags SHALL clear.
REQ-022 The map SHALL be exactly as follows, and every other code SHALL be ignored while still clearing the flags:
  - non-ext: 1D->1A (W), 1B->16 (S), 29->2C (space), 5A->28 (enter), 0D->2B (tab), 66->2A (backspace)
  - ext: 75->52 (up), 72->51 (down)
REQ-023 A make of a mapped key SHALL set keycode to the mapped value, overwriting any previous value (last-pressed wins).
REQ-024 A break of a mapped key SHALL set keycode to 8'h00 only when the mapped value equals the current keycode; otherwise keycode SHALL be unchanged.
REQ-025 keycode SHALL update in the cycle after scan_valid, i.e. 2 cycles after the stop strobe.
REQ-026 Make repeats (typematic) of the held key SHALL leave keycode unchanged.
REQ-027 scan_valid and frame_err SHALL never both be high in the same cycle.

Reset
REQ-028 While Reset is high at a Clk edge, the block SHALL enter IDLE and set keycode, scan_byte, bit counter, timeout counter, ext and brk to 0 and scan_valid and frame_err to 0; the filter state SHALL be forced to 1 (idle high).
REQ-029 Reset asserted mid-frame SHALL discard the partial byte with no scan_valid and no frame_err.

Verification
REQ-030 Frame 0x1D with good parity and stop -> scan_byte=1D, one scan_valid pulse, keycode=1A; then frames F0,1D -> keycode=00.
REQ-031 Frames E0,75 -> keycode=52; then E0,F0,75 -> keycode=00; frames E0,1D -> keycode unchanged (unmapped).
REQ-032 Make 1D then make 29 -> keycode=2C; break 1D -> keycode stays 2C; break 29 -> keycode=00.
REQ-033 Frame 0x1B with wrong parity -> frame_err for 1 cycle, no scan_valid, scan_byte and keycode unchanged; frame 0x1B with stop=0 -> same result.
REQ-034 Start bit plus 4 data bits, then ps2_clk held high for TIMEOUT_CYCLES -> one frame_err pulse; next good frame 0x5A -> keycode=28.
REQ-035 A 3-cycle ps2_clk glitch low (shorter than FILTER_LEN) -> no strobe and no state change; Reset pulsed after 5 bits of a frame -> IDLE, keycode=00, no pulses.
